// File: rtl/bist_sequencer.sv
// BIST sequencer: stores JTAG-loaded test vectors, replays them against the core under test,
// and accumulates pass/fail, error count and first failing index for capture.
module bist_sequencer #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned AW      = 8,
   parameter int unsigned DUT_LAT = 1
) (
   input  logic          clk,
   input  logic          TRST_n,
   input  logic          clr,
   input  logic          load_valid,
   input  logic [9:0]    load_data,
   input  logic          run_start,
   input  logic          abort,
   output logic [4:0]    dut_x,
   input  logic [3:0]    dut_y,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [7:0]    err_count,
   output logic [AW-1:0] first_fail,
   output logic [AW:0]   vec_count,
   output logic          overflow
);

   localparam int unsigned VW = 10;
   localparam int unsigned CW = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_WAIT,
      S_CMP,
      S_DONE
   } state_t;

   state_t          state;
   logic [VW-1:0]   mem [DEPTH];
   logic [AW-1:0]   idx;
   logic [CW-1:0]   lat_cnt;

   logic            load_ok;
   logic [AW:0]     vc_eff;
   logic [VW-1:0]   cur_vec;
   logic            mismatch;
   logic            last_vec;

   // A load in the same cycle as run_start is counted into the run it starts.
   always_comb begin
      load_ok  = load_valid && !busy && (vec_count != (AW+1)'(DEPTH));
      vc_eff   = load_ok ? vec_count + (AW+1)'(1) : vec_count;
      cur_vec  = mem[idx];
      mismatch = !cur_vec[9] && (dut_y != cur_vec[8:5]);
      last_vec = ((AW+1)'(idx) == vec_count - (AW+1)'(1));
   end

   // Vector buffer: no reset, contents only meaningful below vec_count.
   always_ff @(posedge clk) begin
      if (load_ok && !clr)
         mem[vec_count[AW-1:0]] <= load_data;
   end

   always_ff @(posedge clk or negedge TRST_n) begin
      if (!TRST_n) begin
         state      <= S_IDLE;
         idx        <= '0;
         lat_cnt    <= '0;
         dut_x      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         first_fail <= '0;
         vec_count  <= '0;
         overflow   <= 1'b0;
      end else if (clr) begin
         state      <= S_IDLE;
         idx        <= '0;
         lat_cnt    <= '0;
         dut_x      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         first_fail <= '0;
         vec_count  <= '0;
         overflow   <= 1'b0;
      end else begin
         if (load_valid) begin
            if (load_ok)
               vec_count <= vec_count + (AW+1)'(1);
            else
               overflow <= 1'b1;
         end

         case (state)
            S_IDLE, S_DONE: begin
               if (run_start) begin
                  idx        <= '0;
                  err_count  <= '0;
                  first_fail <= '0;
                  if (vc_eff == '0) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end else begin
                     state <= S_APPLY;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                     pass  <= 1'b0;
                  end
               end
            end
            S_APPLY: begin
               dut_x   <= cur_vec[4:0];
               lat_cnt <= '0;
               state   <= (DUT_LAT == 0) ? S_CMP : S_WAIT;
            end
            S_WAIT: begin
               if (lat_cnt == CW'(DUT_LAT - 1))
                  state <= S_CMP;
               else
                  lat_cnt <= lat_cnt + CW'(1);
            end
            S_CMP: begin
               if (mismatch) begin
                  if (err_count != 8'hFF)
                     err_count <= err_count + 8'd1;
                  if (err_count == 8'd0)
                     first_fail <= idx;
               end
               if (last_vec) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == 8'd0) && !mismatch;
               end else begin
                  idx   <= idx + AW'(1);
                  state <= S_APPLY;
               end
            end
            default: state <= S_IDLE;
         endcase

         // Abort overrides whatever the run step decided; results so far are kept.
         if (abort && busy) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench for bist_sequencer against a one-cycle-latency core model Y = X[3:0].
module tb_bist_sequencer;

   localparam int unsigned AW = 8;

   logic          clk;
   logic          TRST_n;
   logic          clr;
   logic          load_valid;
   logic [9:0]    load_data;
   logic          run_start;
   logic          abort;
   logic [4:0]    dut_x;
   logic [3:0]    dut_y;
   logic          busy;
   logic          done;
   logic          pass;
   logic [7:0]    err_count;
   logic [AW-1:0] first_fail;
   logic [AW:0]   vec_count;
   logic          overflow;

   int n_cmp;
   int n_bad;
   int cyc;

   bist_sequencer #(.DEPTH(256), .AW(AW), .DUT_LAT(1)) u_dut (
      .clk        (clk),
      .TRST_n     (TRST_n),
      .clr        (clr),
      .load_valid (load_valid),
      .load_data  (load_data),
      .run_start  (run_start),
      .abort      (abort),
      .dut_x      (dut_x),
      .dut_y      (dut_y),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_count  (err_count),
      .first_fail (first_fail),
      .vec_count  (vec_count),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Core under test: one cycle of latency, Y = X[3:0]
   always_ff @(posedge clk) dut_y <= dut_x[3:0];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [9:0] mk_vec(input logic m, input logic [3:0] e, input logic [4:0] x);
      return {m, e, x};
   endfunction

   // All stimulus tasks start and end just after a falling edge.
   task automatic load(input logic [9:0] v);
      load_valid = 1'b1;
      load_data  = v;
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   // Start a run and count rising edges until done is seen; optional abort / busy-time injection.
   task automatic run_wait(input bit with_ld, input logic [9:0] ld, input int abort_at,
                           input int inject_at, input int max_cyc, output int ncyc);
      run_start = 1'b1;
      if (with_ld) begin
         load_valid = 1'b1;
         load_data  = ld;
      end
      ncyc = 0;
      while (ncyc < max_cyc) begin
         @(posedge clk);
         ncyc++;
         @(negedge clk);
         run_start  = 1'b0;
         load_valid = 1'b0;
         abort      = 1'b0;
         if (done) break;
         if (ncyc == 1) chk("busy_in_run", 32'(busy), 32'd1);
         if (ncyc == abort_at) abort = 1'b1;
         if (ncyc == inject_at) begin
            run_start  = 1'b1;
            load_valid = 1'b1;
            load_data  = 10'h3FF;
         end
      end
      chk("run_done", 32'(done), 32'd1);
      chk("busy_after", 32'(busy), 32'd0);
   endtask

   initial begin
      n_cmp      = 0;
      n_bad      = 0;
      TRST_n     = 1'b0;
      clr        = 1'b0;
      load_valid = 1'b0;
      load_data  = '0;
      run_start  = 1'b0;
      abort      = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_err", 32'(err_count), 32'd0);
      chk("rst_vc", 32'(vec_count), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_x", 32'(dut_x), 32'd0);
      TRST_n = 1'b1;
      @(negedge clk);

      // All-good set with a masked entry: 3*(1+2)+1 = 10 cycles
      do_clr();
      load(mk_vec(1'b0, 4'h4, 5'h04));
      load(mk_vec(1'b0, 4'h2, 5'h02));
      load(mk_vec(1'b1, 4'h0, 5'h1F));
      chk("t2_vc", 32'(vec_count), 32'd3);
      run_wait(1'b0, '0, -1, -1, 100, cyc);
      chk("t2_cyc", 32'(cyc), 32'd10);
      chk("t2_pass", 32'(pass), 32'd1);
      chk("t2_err", 32'(err_count), 32'd0);
      chk("t2_x", 32'(dut_x), 32'h1F);

      // Two mismatches, first at index 1
      do_clr();
      load(mk_vec(1'b0, 4'h5, 5'h05));
      load(mk_vec(1'b0, 4'h7, 5'h06));
      load(mk_vec(1'b0, 4'h8, 5'h09));
      run_wait(1'b0, '0, -1, -1, 100, cyc);
      chk("t3_cyc", 32'(cyc), 32'd10);
      chk("t3_pass", 32'(pass), 32'd0);
      chk("t3_err", 32'(err_count), 32'd2);
      chk("t3_ff", 32'(first_fail), 32'd1);
      // Rerun replays the same set with fresh results
      run_wait(1'b0, '0, -1, -1, 100, cyc);
      chk("t3r_err", 32'(err_count), 32'd2);
      chk("t3r_ff", 32'(first_fail), 32'd1);

      // Empty buffer: done with pass on the next cycle
      do_clr();
      run_wait(1'b0, '0, -1, -1, 100, cyc);
      chk("t5_cyc", 32'(cyc), 32'd1);
      chk("t5_pass", 32'(pass), 32'd1);

      // Load together with run_start: the new vector is part of the run
      run_wait(1'b1, mk_vec(1'b0, 4'h3, 5'h03), -1, -1, 100, cyc);
      chk("ldrun_cyc", 32'(cyc), 32'd4);
      chk("ldrun_vc", 32'(vec_count), 32'd1);
      chk("ldrun_pass", 32'(pass), 32'd1);

      // Abort after two vectors
      do_clr();
      for (int i = 1; i <= 5; i++) begin
         logic [4:0] xv;
         xv = 5'(i);
         load(mk_vec(1'b0, xv[3:0], xv));
      end
      run_wait(1'b0, '0, 7, -1, 100, cyc);
      chk("abort_cyc", 32'(cyc), 32'd8);
      chk("abort_pass", 32'(pass), 32'd0);
      chk("abort_err", 32'(err_count), 32'd0);

      // load_valid + run_start while busy are ignored, overflow set
      run_wait(1'b0, '0, -1, 4, 100, cyc);
      chk("t6_cyc", 32'(cyc), 32'd16);
      chk("t6_ovf", 32'(overflow), 32'd1);
      chk("t6_vc", 32'(vec_count), 32'd5);
      chk("t6_pass", 32'(pass), 32'd1);

      // clr mid-run clears everything
      do_clr();
      load(mk_vec(1'b0, 4'h1, 5'h00));
      load(mk_vec(1'b0, 4'h2, 5'h02));
      run_start = 1'b1;
      @(negedge clk);
      run_start  = 1'b0;
      load_valid = 1'b1;
      load_data  = '0;
      @(negedge clk);
      load_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("clr_pre_err", 32'(err_count), 32'd1);
      chk("clr_pre_ovf", 32'(overflow), 32'd1);
      chk("clr_pre_busy", 32'(busy), 32'd1);
      do_clr();
      chk("clr_busy", 32'(busy), 32'd0);
      chk("clr_done", 32'(done), 32'd0);
      chk("clr_vc", 32'(vec_count), 32'd0);
      chk("clr_err", 32'(err_count), 32'd0);
      chk("clr_ff", 32'(first_fail), 32'd0);
      chk("clr_ovf", 32'(overflow), 32'd0);
      chk("clr_x", 32'(dut_x), 32'd0);

      // Full buffer: 257th load dropped; only the last entry fails
      do_clr();
      for (int i = 0; i <= 256; i++) begin
         logic [8:0] iv;
         iv = 9'(i);
         if (i == 255) load(mk_vec(1'b0, ~iv[3:0], iv[4:0]));
         else          load(mk_vec(1'b0, iv[3:0], iv[4:0]));
      end
      chk("t4_vc", 32'(vec_count), 32'd256);
      chk("t4_ovf", 32'(overflow), 32'd1);
      run_wait(1'b0, '0, -1, -1, 2000, cyc);
      chk("t4_cyc", 32'(cyc), 32'd769);
      chk("t4_err", 32'(err_count), 32'd1);
      chk("t4_ff", 32'(first_fail), 32'd255);
      chk("t4_pass", 32'(pass), 32'd0);
      chk("t4_x", 32'(dut_x), 32'h1F);

      // Asynchronous reset mid-run
      run_start = 1'b1;
      @(negedge clk);
      run_start = 1'b0;
      repeat (4) @(negedge clk);
      chk("t1_pre_busy", 32'(busy), 32'd1);
      TRST_n = 1'b0;
      #1;
      chk("t1_busy", 32'(busy), 32'd0);
      chk("t1_done", 32'(done), 32'd0);
      chk("t1_x", 32'(dut_x), 32'd0);
      chk("t1_vc", 32'(vec_count), 32'd0);
      chk("t1_ovf", 32'(overflow), 32'd0);
      @(negedge clk);
      TRST_n = 1'b1;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
